serial_mux_adder_ctrl: RTL and testbench
========================================

// Module: serial_mux_adder_ctrl
// PURPOSE
//  Bit-serial adder controller: sequences one mux-based full-adder slice (8:1 mux truth tables) over a WIDTH-bit word.
//  Loads operands on start, then feeds LSB-first bit triples {a,b,carry} to the slice, one bit per clock.
//  Collects sum bits into a shift register and pulses done.
//  Top-level arithmetic unit for the lab datapath, replacing WIDTH parallel adder slices.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits (>=2)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A, captured on accepted start
//  b       in   WIDTH  operand B, captured on accepted start
//  cin     in   1      carry-in, captured on accepted start
//  busy    out  1      high in RUN and DONE
//  done    out  1      one-cycle pulse: sum/cout valid
//  sum     out  WIDTH  result; held until next accepted start
//  cout    out  1      final carry; held with sum
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry reg=0. Reset applies in any state.
//    A mid-RUN reset abandons the operation; no done pulse.
//  - FSM IDLE->RUN->DONE->IDLE.
//    IDLE: start=1 -> capture a,b into shift regs, carry<=cin, cnt<=0, go RUN.
//    RUN: slice inputs {a_sh[0],b_sh[0],carry}.
//      Slice sum  = 8'b1001_0110[{a,b,c}]
//      Slice cout = 8'b1110_1000[{a,b,c}]
//      Sum bit shifts into sum_sh MSB; a_sh/b_sh shift right; carry<=slice cout; cnt++.
//      Go DONE when cnt==WIDTH-1.
//    DONE: sum<=sum_sh, cout<=carry, done=1 for exactly this cycle; go IDLE unconditionally.
//  - Latency: start accepted at edge N; done=1 during the cycle after edge N+WIDTH+1. Throughput: one op per WIDTH+2 cycles.
//  - start while busy (RUN or DONE) is ignored, not queued. a/b/cin changing after capture have no effect.
//  - Arithmetic is modulo 2^WIDTH; overflow is reported only via cout.
//  - sum/cout update only in DONE; they are stable in all other states.
//  - cnt width = $clog2(WIDTH); wrap is never reached (exit at WIDTH-1).
// CONFIGURATION
//  SERIAL_ADD_SUB_EN defined:
//    - Adds input port sub (1 bit), captured with start.
//    - sub=1: B is captured inverted and carry<=1 (cin ignored) -> sum=a-b, cout=1 means no borrow.
//    - sub=0: identical to add.
//  SERIAL_ADD_SUB_EN undefined: no sub port; add-only.
// STRUCTURE
//  - Package serial_adder_pkg:
//    - State typedef {IDLE=2'd0, RUN=2'd1, DONE=2'd2}
//    - Localparams FA_SUM_TT=8'h96 and FA_COUT_TT=8'hE8.
//  - One sub-module fa_mux8_slice: combinational {a,b,c} -> {s,co} via 8:1 mux on the package tables.
//  - The controller holds the FSM, counter, shift registers and carry register.
// TESTING
//  1. a=8'h3C, b=8'h0F, cin=0, start 1 cycle -> after 10 cycles done=1, sum=8'h4B, cout=0; busy high 9 cycles.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple).
//  3. a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1; then a=0, b=0, cin=0 -> sum=0, cout=0.
//  4. Pulse start again 3 cycles into op (different a/b) -> ignored; result matches first operands; one done pulse only.
//  5. rst=1 for 1 cycle mid-RUN (cnt=4) -> next cycle busy=0, sum=0, cout=0, no done; new start completes normally.
//  6. (SERIAL_ADD_SUB_EN) sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1; a=8'h01, b=8'h02 -> sum=8'hFF, cout=0.
//  Bench checks every op against a+b+cin (or a-b) reference model, plus done pulse width == 1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and truth tables for the bit-serial mux-slice adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] FA_SUM_TT  = 8'h96;
  localparam logic [7:0] FA_COUT_TT = 8'hE8;

  // 8:1 mux over a truth table, select = {a,b,c}
  function automatic logic tt_mux8(input logic [7:0] tt, input logic [2:0] sel);
    logic bit_v;
    case (sel)
      3'd0:    bit_v = tt[0];
      3'd1:    bit_v = tt[1];
      3'd2:    bit_v = tt[2];
      3'd3:    bit_v = tt[3];
      3'd4:    bit_v = tt[4];
      3'd5:    bit_v = tt[5];
      3'd6:    bit_v = tt[6];
      3'd7:    bit_v = tt[7];
      default: bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/serial_mux_adder_ctrl_slice.sv
// fa_mux8_slice: one combinational full-adder bit built from two 8:1 muxes.
module fa_mux8_slice
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic [2:0] sel_s;

  assign sel_s = {a, b, c};
  assign s     = tt_mux8(FA_SUM_TT, sel_s);
  assign co    = tt_mux8(FA_COUT_TT, sel_s);

endmodule

// File: rtl/serial_mux_adder_ctrl.sv
// Bit-serial adder controller: feeds one fa_mux8_slice LSB-first over a WIDTH-bit word.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for a-b (B inverted, carry-in forced to 1).
module serial_mux_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             slice_sum_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;

  fa_mux8_slice u_slice (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .c  (carry_r),
    .s  (slice_sum_s),
    .co (slice_cout_s)
  );

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand B and initial carry as captured on an accepted start
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
`endif
  end

  // State, datapath shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= {WIDTH{1'b0}};
      cout     <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      // done is seen the cycle after DONE, together with the freshly loaded sum/cout
      done    <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b_load_s;
            carry_r <= carry_load_s;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        RUN: begin
          sum_sh_r <= {slice_sum_s, sum_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= slice_cout_s;
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        DONE: begin
          sum  <= sum_sh_r;
          cout <= carry_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mux_adder_ctrl.sv
// Self-checking bench for serial_mux_adder_ctrl: directed and random ops against an arithmetic model.
module tb_serial_mux_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  serial_mux_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: expected result from plain arithmetic, optional ignored start at cycle inject_at
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tcin, input logic tsub, input int inject_at);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    int               busy_cnt;
    int               lat;
    if (tsub) begin
      exp_sum  = ta - tb_v;
      exp_cout = (ta >= tb_v);
    end else begin
      full     = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tcin};
      exp_sum  = full[WIDTH-1:0];
      exp_cout = full[WIDTH];
    end
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = tsub;
`endif
    @(posedge clk); #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat      = -1;
    for (int k = 1; k <= WIDTH + 6; k++) begin
      @(negedge clk);
      a   = $urandom();
      b   = $urandom();
      cin = 1'($urandom());
      start = (k == inject_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, WIDTH + 1);
    check({tag, " busy_cycles"}, busy_cnt, WIDTH + 1);
    check({tag, " sum"}, sum, exp_sum);
    check({tag, " cout"}, cout, exp_cout);
    @(posedge clk); #1;
    check({tag, " done_width"}, done, 1'b0);
    check({tag, " sum_held"}, sum, exp_sum);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;
    int               done_cnt;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("t1", 8'h3C, 8'h0F, 1'b0, 1'b0, 0);
    run_op("t2", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op("t3a", 8'h5A, 8'hA5, 1'b1, 1'b0, 0);
    run_op("t3b", 8'h00, 8'h00, 1'b0, 1'b0, 0);
    run_op("t4", 8'h37, 8'h42, 1'b0, 1'b0, 3);

    // Reset while the counter is at 4
    @(negedge clk);
    a = 8'hC3; b = 8'h21; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5 busy", busy, 1'b0);
    check("t5 done", done, 1'b0);
    check("t5 sum", sum, 0);
    check("t5 cout", cout, 1'b0);
    done_cnt = 0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("t5 no_done", done_cnt, 0);
    run_op("t5 after", 8'h81, 8'h7E, 1'b1, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("t6a", 8'h10, 8'h01, 1'b0, 1'b1, 0);
    run_op("t6b", 8'h01, 8'h02, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      rc = 1'($urandom());
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom());
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, (i % 4 == 0) ? 2 + (i % 5) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
